// File: rtl/dct_loader_pkg.sv
// Shared types and constants for the DCT block loader.
package dct_loader_pkg;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_WAIT_OUT = 2'd2
  } state_t;

  // JPEG level shift applied to every written sample when enabled.
  localparam int LEVEL_SHIFT = 128;

  // Default block geometry (8x8) and the matching buffer address width.
  localparam int NUM_WORDS_DEF = 64;
  localparam int ADDR_W_DEF    = $clog2(NUM_WORDS_DEF);

endpackage

// File: rtl/dct_block_loader_sample_buffer.sv
// One-block sample store: one write port, one registered read port.
// Contents are never reset; the loader only reads words it wrote this
// block, and substitutes zero for everything above the fill count.
module sample_buffer
  import dct_loader_pkg::*;
#(
  parameter int DEPTH  = NUM_WORDS_DEF,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store one completed sample.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: one-cycle registered read.
  always_ff @(posedge i_clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dct_block_loader.sv
// Byte-stream to 16-bit sample block loader in front of dct_2d.
// Packs little-endian byte pairs, buffers one block, then streams it
// out one sample per cycle with zero padding past the fill count.
// Optional feature: define DCT_LOADER_LEVEL_SHIFT_EN to subtract 128
// from every written sample (JPEG level shift).
//
// Handshake: a byte transfers on a rising edge where o_tready and
// i_tdata_valid are both high; i_tdata/i_tdata_last must be stable while
// i_tdata_valid is high and o_tready is low. o_enb marks a valid o_data
// and there is no back-pressure on the output side.
module dct_block_loader
  import dct_loader_pkg::*;
#(
  parameter int WRITE_DATA_WIDTH = 8,
  parameter int READ_DATA_WIDTH  = 16,
  parameter int NUM_WORDS        = NUM_WORDS_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_tdata_valid,
  input  logic [WRITE_DATA_WIDTH-1:0] i_tdata,
  input  logic                        i_tdata_last,
  input  logic                        i_output_last,
  output logic                        o_tready,
  output logic [READ_DATA_WIDTH-1:0]  o_data,
  output logic                        o_enb,
  output logic [1:0]                  o_state_dbg
);

  localparam int ADDR_W = $clog2(NUM_WORDS);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] N_CNT     = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(NUM_WORDS + 1);

  state_t                      state;
  logic [CNT_W-1:0]            fill_cnt;
  logic [CNT_W-1:0]            drain_idx;
  logic                        have_low;
  logic                        last_seen;
  logic [WRITE_DATA_WIDTH-1:0] low_q;
  logic                        rd_valid;
  logic                        pad_q;
  logic [READ_DATA_WIDTH-1:0]  rd_data;

  logic                        accept;
  logic                        wr_en;
  logic                        blk_done;
  logic                        rd_en;
  logic [READ_DATA_WIDTH-1:0]  wr_word;
  logic [READ_DATA_WIDTH-1:0]  wr_data;

  assign o_state_dbg = state;
  // o_tready is only ever high in FILL, so it alone qualifies a transfer.
  assign accept = i_tdata_valid && o_tready;
  assign rd_en  = (state == ST_DRAIN) && (drain_idx < N_CNT);

  // Pair assembly: a high byte, or a lone low byte marked last, completes a word.
  always_comb begin
    wr_en    = 1'b0;
    blk_done = 1'b0;
    wr_word  = '0;
    if (accept) begin
      if (!have_low) begin
        if (i_tdata_last) begin
          wr_en    = 1'b1;
          wr_word  = {{WRITE_DATA_WIDTH{1'b0}}, i_tdata};
          blk_done = 1'b1;
        end
      end else begin
        wr_en    = 1'b1;
        wr_word  = {i_tdata, low_q};
        blk_done = i_tdata_last || (fill_cnt == LAST_WORD);
      end
    end
  end

`ifdef DCT_LOADER_LEVEL_SHIFT_EN
  assign wr_data = wr_word - READ_DATA_WIDTH'(LEVEL_SHIFT);
`else
  assign wr_data = wr_word;
`endif

  sample_buffer #(
    .DEPTH  (NUM_WORDS),
    .WIDTH  (READ_DATA_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .i_clk   (i_clk),
    .wr_en   (wr_en),
    .wr_addr (fill_cnt[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (drain_idx[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  // Control FSM: fill the buffer, drain it, then hold until the answer is sent.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ST_FILL;
      fill_cnt  <= '0;
      drain_idx <= '0;
      have_low  <= 1'b0;
      low_q     <= '0;
      last_seen <= 1'b0;
      o_tready  <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          o_tready <= 1'b1;
          if (accept) begin
            if (!have_low && !i_tdata_last) begin
              low_q    <= i_tdata;
              have_low <= 1'b1;
            end else begin
              have_low <= 1'b0;
            end
            if (wr_en) fill_cnt <= fill_cnt + CNT_W'(1);
            if (blk_done) begin
              state     <= ST_DRAIN;
              o_tready  <= 1'b0;
              drain_idx <= '0;
              last_seen <= i_tdata_last;
            end
          end
        end
        ST_DRAIN: begin
          o_tready <= 1'b0;
          // Two extra steps let the read and output registers empty first.
          if (drain_idx == DRAIN_END) begin
            drain_idx <= '0;
            if (last_seen) begin
              state <= ST_WAIT_OUT;
            end else begin
              state    <= ST_FILL;
              fill_cnt <= '0;
              o_tready <= 1'b1;
            end
          end else begin
            drain_idx <= drain_idx + CNT_W'(1);
          end
        end
        ST_WAIT_OUT: begin
          o_tready <= 1'b0;
          if (i_output_last) begin
            state     <= ST_FILL;
            fill_cnt  <= '0;
            last_seen <= 1'b0;
            o_tready  <= 1'b1;
          end
        end
        default: begin
          state    <= ST_FILL;
          o_tready <= 1'b0;
        end
      endcase
    end
  end

  // Output pipeline: track the read in flight and substitute zero padding.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_valid <= 1'b0;
      pad_q    <= 1'b0;
      o_enb    <= 1'b0;
      o_data   <= '0;
    end else begin
      rd_valid <= rd_en;
      pad_q    <= (drain_idx >= fill_cnt);
      o_enb    <= rd_valid;
      if (rd_valid) o_data <= pad_q ? '0 : rd_data;
    end
  end

endmodule

// File: tb/tb_dct_block_loader.sv
// Directed scoreboard bench for dct_block_loader.
module tb_dct_block_loader;

  localparam int NW = 64;
  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic        clk;
  logic        rst_n;
  logic        tvalid;
  logic [7:0]  tdata;
  logic        tlast;
  logic        out_last;
  logic        tready;
  logic [15:0] data;
  logic        enb;
  logic [1:0]  st;

  logic [15:0] exp_q[$];
  logic [7:0]  tx_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  dct_block_loader #(
    .WRITE_DATA_WIDTH (8),
    .READ_DATA_WIDTH  (16),
    .NUM_WORDS        (NW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_tdata_valid (tvalid),
    .i_tdata       (tdata),
    .i_tdata_last  (tlast),
    .i_output_last (out_last),
    .o_tready      (tready),
    .o_data        (data),
    .o_enb         (enb),
    .o_state_dbg   (st)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected sample after the optional level shift
  function automatic logic [15:0] sh(input logic [15:0] w);
`ifdef DCT_LOADER_LEVEL_SHIFT_EN
    return w - 16'd128;
`else
    return w;
`endif
  endfunction

  task automatic push_pad(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(16'h0000);
  endtask

  // Scoreboard monitor: every o_enb cycle must match the queue head
  always @(negedge clk) begin
    if (enb) begin
      if (exp_q.size() == 0) check("extra_sample_enb", {31'b0, enb}, 32'd0);
      else check("sample", {16'b0, data}, {16'b0, exp_q.pop_front()});
    end
  end

  // Driver: present one byte, hold until accepted (bounded)
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int   waited;
    logic ok;
    if (gap > 0) begin
      tvalid = 1'b0;
      tlast  = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    tvalid = 1'b1;
    tdata  = b;
    tlast  = last;
    waited = 0;
    ok     = 1'b0;
    while (!ok && waited < 300) begin
      @(negedge clk);
      ok = tready;
      @(posedge clk);
      waited++;
    end
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    if (!ok) check("accept_timeout", {31'b0, ok}, 32'd1);
  endtask

  // Send everything in tx_q; the final byte carries last when use_last is set
  task automatic send_tx(input int max_gap, input logic use_last);
    logic [7:0] b;
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      send_byte(b, use_last && (tx_q.size() == 0), $urandom_range(0, max_gap));
    end
  endtask

  task automatic wait_q_size(input int target, input string name);
    int w = 0;
    while (exp_q.size() != target && w < 400) begin
      @(posedge clk);
      w++;
    end
    check(name, exp_q.size(), target);
  endtask

  task automatic out_pulse();
    out_last = 1'b1;
    @(posedge clk);
    #1;
    out_last = 1'b0;
  endtask

  // Stimulus
  initial begin
    rst_n    = 1'b0;
    tvalid   = 1'b0;
    tdata    = 8'h00;
    tlast    = 1'b0;
    out_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", {31'b0, tready}, 32'd0);
    check("rst_enb", {31'b0, enb}, 32'd0);
    check("rst_data", {16'b0, data}, 32'd0);
    check("rst_state", {30'b0, st}, {30'b0, S_FILL});
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("tready_before_edge", {31'b0, tready}, 32'd0);
    @(negedge clk);
    check("tready_after_release", {31'b0, tready}, 32'd1);
    @(posedge clk);
    #1;

    // Full block 0x00..0x7F with last on the final byte
    for (int i = 0; i < 128; i++) tx_q.push_back(8'(i));
    for (int i = 0; i < NW; i++) exp_q.push_back(sh({8'(2 * i + 1), 8'(2 * i)}));
    send_tx(0, 1'b1);
    @(negedge clk);
    check("full_tready_low_at_k", {31'b0, tready}, 32'd0);
    @(posedge clk);
    #1;
    wait_q_size(0, "full_drain");
    #1;
    // Bytes offered while o_tready is low must not be taken
    tvalid = 1'b1;
    tdata  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait_tready_low", {31'b0, tready}, 32'd0);
      check("wait_state", {30'b0, st}, {30'b0, S_WAIT});
    end
    @(posedge clk);
    #1 tvalid = 1'b0;
    out_pulse();
    @(negedge clk);
    check("tready_after_output_last", {31'b0, tready}, 32'd1);
    @(posedge clk);
    #1;
    // The 0x55 must not appear as a pending low byte
    tx_q.push_back(8'h11);
    exp_q.push_back(sh(16'h0011));
    push_pad(NW - 1);
    send_tx(0, 1'b1);
    wait_q_size(0, "lone_byte_drain");
    #1 out_pulse();

    // Short packet with an ignored output_last pulse in FILL
    for (int i = 1; i <= 3; i++) tx_q.push_back(8'(i));
    exp_q.push_back(sh(16'h0201));
    exp_q.push_back(sh(16'h0403));
    exp_q.push_back(sh(16'h0005));
    push_pad(NW - 3);
    send_tx(1, 1'b0);
    out_pulse();
    @(negedge clk);
    check("fill_ignores_output_last", {30'b0, st}, {30'b0, S_FILL});
    check("fill_tready_kept", {31'b0, tready}, 32'd1);
    @(posedge clk);
    #1;
    send_byte(8'h04, 1'b0, 0);
    send_byte(8'h05, 1'b1, 0);
    @(negedge clk);
    check("short_enb_k", {31'b0, enb}, 32'd0);
    @(negedge clk);
    check("short_enb_k1", {31'b0, enb}, 32'd0);
    @(negedge clk);
    check("short_enb_k2", {31'b0, enb}, 32'd1);
    @(posedge clk);
    #1;
    wait_q_size(0, "short_drain");
    #1;
    check("short_wait_state", {30'b0, st}, {30'b0, S_WAIT});
    out_pulse();

    // Two blocks of 0xAA with random valid gaps
    for (int i = 0; i < 2 * NW; i++) exp_q.push_back(sh(16'hAAAA));
    for (int i = 0; i < 128; i++) tx_q.push_back(8'hAA);
    send_tx(3, 1'b0);
    wait_q_size(NW, "first_burst");
    @(negedge clk);
    check("between_bursts_tready", {31'b0, tready}, 32'd1);
    check("between_bursts_state", {30'b0, st}, {30'b0, S_FILL});
    for (int i = 0; i < 128; i++) tx_q.push_back(8'hAA);
    send_tx(3, 1'b1);
    wait_q_size(0, "second_burst");
    #1;
    check("second_burst_wait_state", {30'b0, st}, {30'b0, S_WAIT});
    check("second_burst_tready", {31'b0, tready}, 32'd0);
    out_pulse();

    // Reset at sample 20 of a drain
    for (int i = 0; i < 128; i++) tx_q.push_back(8'(3 * i + 7));
    for (int i = 0; i < 20; i++) exp_q.push_back(sh({8'(3 * (2 * i + 1) + 7), 8'(3 * (2 * i) + 7)}));
    send_tx(0, 1'b1);
    wait_q_size(0, "pre_reset_samples");
    #1 rst_n = 1'b0;
    #1 check("reset_enb_immediate", {31'b0, enb}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold_enb", {31'b0, enb}, 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_tready", {31'b0, tready}, 32'd1);
    check("post_reset_state", {30'b0, st}, {30'b0, S_FILL});
    @(posedge clk);
    #1;
    for (int i = 0; i < 128; i++) tx_q.push_back(8'(255 - i));
    for (int i = 0; i < NW; i++) exp_q.push_back(sh({8'(255 - (2 * i + 1)), 8'(255 - 2 * i)}));
    send_tx(2, 1'b1);
    wait_q_size(0, "post_reset_drain");
    #1 out_pulse();

    // Level-shift vectors: 00 00 80 00
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h80);
    tx_q.push_back(8'h00);
    exp_q.push_back(sh(16'h0000));
    exp_q.push_back(sh(16'h0080));
    push_pad(NW - 2);
    send_tx(0, 1'b1);
    wait_q_size(0, "shift_drain");
    #1 out_pulse();

    repeat (4) @(negedge clk);
    check("final_no_extra_enb", {31'b0, enb}, 32'd0);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
